// File: rtl/btn_debounce_step.sv
// btn_debounce_step: debounces one raw push-button into a clean level,
// single-cycle press/release events, an optional auto-repeat strobe and a
// CPU single-step strobe (press or repeat). Everything runs on clk_in.
module btn_debounce_step #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat,
  output logic btn_step
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so it can never wrap.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]   DLY_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0]   PER_LAST = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_t;

  logic          sync1_q, sync2_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rcnt_q;
  logic          periodic_q;   // 0: waiting out the first delay, 1: periodic
  logic          level_q, press_q, release_q, repeat_q, step_q;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM with auto-repeat; every output is a register set on the
  // same edge as the transition that produces it.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      periodic_q <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_q <= CONFIRM_PRESS;
            cnt_q   <= '0;
          end
        end
        CONFIRM_PRESS: begin
          if (!sync2_q) begin
            state_q <= IDLE;          // glitch, drop silently
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= HELD;
            level_q    <= 1'b1;
            press_q    <= 1'b1;
            step_q     <= 1'b1;
            rcnt_q     <= '0;
            periodic_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (!sync2_q) begin
            state_q <= CONFIRM_RELEASE;
            cnt_q   <= '0;
          end
          // Repeat timer only advances in HELD; it is frozen (not cleared)
          // during a release confirm so a glitch resumes the count.
          if (REPEAT_EN) begin
            if (rcnt_q == (periodic_q ? PER_LAST : DLY_LAST)) begin
              repeat_q   <= 1'b1;
              step_q     <= 1'b1;
              rcnt_q     <= '0;
              periodic_q <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + 32'd1;
            end
          end
        end
        CONFIRM_RELEASE: begin
          if (sync2_q) begin
            state_q <= HELD;          // glitch, drop silently
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;
  assign btn_step    = step_q;

endmodule

// File: tb/tb_btn_debounce_step.sv
// Bench for btn_debounce_step: two instances (auto-repeat off and on) share
// one stimulus stream; each edge is checked against a run-length model.
module tb_btn_debounce_step;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic btn_in = 1'b0;

  logic lvl0, prs0, rel0, rep0, stp0;
  logic lvl1, prs1, rel1, rep1, stp1;

  btn_debounce_step #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                      .REPEAT_EN(1'b0)) u_norep (
    .clk_in(clk_in), .reset(reset), .btn_in(btn_in),
    .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0),
    .btn_repeat(rep0), .btn_step(stp0));

  btn_debounce_step #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                      .REPEAT_EN(1'b1)) u_rep (
    .clk_in(clk_in), .reset(reset), .btn_in(btn_in),
    .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1),
    .btn_repeat(rep1), .btn_step(stp1));

  always #5 clk_in = ~clk_in;

  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  string phase    = "init";

  // Model: a change is accepted once the synchronized input has disagreed
  // with the debounced level for D+1 consecutive samples. Repeats fire when
  // the number of edges spent in HELD since the press hits RD, RD+RP, ...
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0;
  int   m_run = 0, m_ticks = 0;
  logic e_press = 1'b0, e_rel = 1'b0, e_rep = 1'b0;

  function automatic void model_edge(input logic b, input logic r);
    logic held_pre;
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
      m_run = 0; m_ticks = 0;
      e_press = 1'b0; e_rel = 1'b0; e_rep = 1'b0;
    end else begin
      held_pre = m_level && (m_run == 0);
      e_press = 1'b0; e_rel = 1'b0; e_rep = 1'b0;
      if (m_s2 != m_level) m_run++;
      else                 m_run = 0;
      if (m_run == D + 1) begin
        m_level = ~m_level;
        m_run   = 0;
        if (m_level) begin
          e_press = 1'b1;
          m_ticks = 0;
        end else begin
          e_rel = 1'b1;
        end
      end
      if (held_pre) begin
        m_ticks++;
        if (m_ticks >= RD && ((m_ticks - RD) % RP) == 0) e_rep = 1'b1;
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
  endfunction

  task automatic step(input logic b, input logic r);
    logic [4:0] obs0, obs1, exp0, exp1;
    btn_in = b;
    reset  = r;
    @(posedge clk_in);
    #1;
    cyc++;
    model_edge(b, r);
    exp0 = {m_level, e_press, e_rel, 1'b0, e_press};
    exp1 = {m_level, e_press, e_rel, e_rep, e_press | e_rep};
    obs0 = {lvl0, prs0, rel0, rep0, stp0};
    obs1 = {lvl1, prs1, rel1, rep1, stp1};
    n_assert++;
    assert (obs0 === exp0) else begin
      n_fail++;
      $error("FAIL %s norep cyc %0d {lvl,prs,rel,rep,stp}: observed %b expected %b",
             phase, cyc, obs0, exp0);
    end
    n_assert++;
    assert (obs1 === exp1) else begin
      n_fail++;
      $error("FAIL %s rep cyc %0d {lvl,prs,rel,rep,stp}: observed %b expected %b",
             phase, cyc, obs1, exp1);
    end
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    logic [8:0] bounce;
    // Reset with a randomly toggling button: outputs stay 0 throughout.
    phase = "reset_vals";
    for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'b1);
    step(1'b0, 1'b0);
    run(1'b0, 4);

    // Clean press: 20 cycles high, then low long enough to release.
    phase = "clean";
    run(1'b1, 20);
    run(1'b0, 12);

    // Bounce that never stays high for D+1 synchronized samples.
    phase = "bounce";
    bounce = 9'b101101110;
    for (int i = 8; i >= 0; i--) step(bounce[i], 1'b0);
    run(1'b0, 10);

    // Release glitch: 3 low samples inside HELD, then high again.
    phase = "rel_glitch";
    run(1'b1, 12);
    run(1'b0, 3);
    run(1'b1, 10);
    run(1'b0, 12);

    // Auto-repeat: long hold, then release.
    phase = "autorep";
    run(1'b1, 30);
    run(1'b0, 15);

    // Reset mid-hold with the button still down.
    phase = "rst_hold";
    run(1'b1, 12);
    step(1'b1, 1'b1);
    run(1'b1, 15);
    run(1'b0, 12);

    // Random runs of random length with occasional resets.
    phase = "random";
    for (int k = 0; k < 80; k++) begin
      int   len;
      logic b, r;
      len = $urandom_range(1, 14);
      b   = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 24) == 0);
      for (int j = 0; j < len; j++) step(b, r && (j == 0));
    end
    run(1'b0, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce_step.md
# btn_debounce_step

Debounces one raw board push-button and turns it into clean single-cycle events for the CPU/display top level. It sits directly upstream of the seven-segment/CPU top, on the `clk_in` (100 MHz) domain. It supplies the debounced level for the system reset line and a one-cycle step pulse for single-stepping `clk_cpu`. An optional auto-repeat produces periodic step pulses while the button is held.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: input must be stable this many cycles (10 ms at 100 MHz) before a state change is accepted; legal range is ≥ 2.
- `REPEAT_DELAY`, default 50000000: cycles in HELD before the first repeat pulse; legal range is ≥ 1.
- `REPEAT_PERIOD`, default 10000000: cycles between later repeat pulses; legal range is ≥ 1.
- `REPEAT_EN`, default 0: 1 enables auto-repeat; 0 forces `btn_repeat` low.

Ports:
- `clk_in`, input, 1 bit: the single clock; all state changes on its rising edge.
- `reset`, input, 1 bit: synchronous, active-high; sampled on the `clk_in` rising edge.
- `btn_in`, input, 1 bit: raw asynchronous button, active-high.
- `btn_level`, output, 1 bit: debounced button level.
- `btn_press`, output, 1 bit: one-cycle pulse on an accepted press.
- `btn_release`, output, 1 bit: one-cycle pulse on an accepted release.
- `btn_repeat`, output, 1 bit: one-cycle auto-repeat pulse.
- `btn_step`, output, 1 bit: `btn_press | btn_repeat`; this is the CPU single-step strobe.

## Operation
- **Synchronizer.** `btn_in` passes through a 2-flop synchronizer (`sync1`, `sync2`). Only `sync2` feeds the FSM.
- **FSM states.** IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE. A debounce counter `cnt` is $clog2(DEBOUNCE_CYCLES) bits wide.
- **IDLE.**
  - `sync2`=1: go to CONFIRM_PRESS, `cnt`←0.
  - Otherwise stay.
- **CONFIRM_PRESS.**
  - `sync2`=0: back to IDLE, `cnt`←0. This is glitch rejection, with no output.
  - `sync2`=1 and `cnt`==DEBOUNCE_CYCLES-1: go to HELD and assert `btn_press` for one cycle.
  - Otherwise `cnt`++.
- **HELD.**
  - `sync2`=0: go to CONFIRM_RELEASE, `cnt`←0.
  - Otherwise stay.
- **CONFIRM_RELEASE.**
  - `sync2`=1: back to HELD, with no output.
  - `sync2`=0 and `cnt`==DEBOUNCE_CYCLES-1: go to IDLE and assert `btn_release` for one cycle.
  - Otherwise `cnt`++.
- **`btn_level`.** 1 in HELD and CONFIRM_RELEASE; 0 in IDLE and CONFIRM_PRESS.
- **Auto-repeat counter.** `rcnt` is 32 bits. It is cleared on entry to HELD from CONFIRM_PRESS.
  - It increments only while in HELD.
  - It holds its value in CONFIRM_RELEASE. A glitch back to HELD resumes the count without restarting it.
- **First repeat.** When `rcnt` reaches REPEAT_DELAY-1 in HELD, `btn_repeat` pulses once and the phase switches to periodic.
- **Later repeats.** `rcnt`←0 on each pulse. Further pulses occur at every `rcnt`==REPEAT_PERIOD-1.
- **Repeat after release.** No repeat pulse is produced after the FSM leaves HELD for IDLE. The repeat phase resets to "delay" on the next press.
- **Pulse exclusivity.** `btn_press`, `btn_release` and `btn_repeat` are mutually exclusive by construction. `btn_step` is never high for more than one cycle per event.
- **`cnt` range.** `cnt` never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.

## Timing
- **Registered outputs.** All outputs are registered with no combinational path from `btn_in`.
- **Reset.** While `reset`=1 at a rising edge:
  - `sync1`, `sync2` ←0; state←IDLE; `cnt`, `rcnt` ←0.
  - All outputs are 0 from the following cycle.
  - Reset mid-confirm or mid-hold discards the event: no `btn_release` is ever emitted for a press interrupted by reset.
- **Press latency.** Take edge 0 as the first edge sampling `btn_in`=1, with `btn_in` stable thereafter.
  - `sync2`=1 after edge 1; CONFIRM_PRESS with `cnt`=0 after edge 2.
  - HELD is entered and `btn_press` goes high at edge DEBOUNCE_CYCLES+2.
  - `btn_press` is high for exactly one cycle.
- **Release latency.** Symmetric to press: `btn_release` goes high at edge DEBOUNCE_CYCLES+2 after the first low sample.
- **First repeat timing.** `btn_repeat` first goes high REPEAT_DELAY edges after `btn_press`.
- **Repeat spacing.** Later `btn_repeat` pulses are REPEAT_PERIOD edges apart, provided the input is held cleanly.
- **Minimum glitch rejected.** Any input pulse shorter than DEBOUNCE_CYCLES+1 synchronized cycles produces no output event.

## Test plan
Run with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 unless noted.
- **Clean press/release.** Hold `btn_in`=1 for 20 cycles, then 0. Required: `btn_press` pulses exactly once at edge 6; `btn_level` rises at edge 6; `btn_release` pulses once 6 edges after the falling sample; no `btn_repeat` (REPEAT_EN=0).
- **Bounce rejection.** Toggle `btn_in` 1,0,1,1,0,1,1,1,0 and then hold 0. Required: no `btn_press`, `btn_level` stays 0, FSM ends in IDLE.
- **Release glitch.** After HELD, drive 0 for 3 cycles, then 1. Required: `btn_level` stays 1, no `btn_release`, FSM returns to HELD.
- **Auto-repeat (REPEAT_EN=1).** Hold `btn_in`=1 for 30 cycles. Required: `btn_press` at edge 6; `btn_repeat` at edges 16, 19, 22, 25, 28…; `btn_step` equals the OR of the two, one cycle each; no repeat after release.
- **Reset mid-hold.** Press, reach HELD, then assert `reset` for 1 cycle while `btn_in`=1 is kept. Required: all outputs 0 the next cycle, no `btn_release`, then a fresh `btn_press` DEBOUNCE_CYCLES+3 edges after reset deasserts.
- **Reset values.** Assert `reset` with `btn_in` toggling randomly. Required: every output reads 0 throughout reset and on the first cycle after it.
